csr_stage: RTL and testbench

CSR_STAGE -- requirements
Module: csr_stage

---
 rtl/csr_stage.sv | 201 ++++++++++++++++++++
 tb/tb_csr_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_stage.sv
// csr_stage: machine-mode CSR execute stage with timer interrupt and trap control.
//
// Every executed CSR / ECALL / MRET instruction, and every interrupt taken on a
// new instruction, costs two cycles. The first is an IDLE cycle with stall=1.
// The second is an EXEC cycle that performs the action and may pulse trap_flg.
// A per-issue instruction tag guards against executing the same instruction
// twice while upstream holds it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_valid                  stage holds a valid instruction
//   csr_reg_pc                 PC of that instruction
//   csr_inst                   raw instruction, CSR address in [31:20]
//   csr_inst_id                unique per-issue instruction tag
//   csr_cmd                    0 NONE, 1 RW, 2 RS, 3 RC, 4 ECALL, 5 MRET
//   csr_op1                    rs1 value or zero-extended zimm
//   reg_cycle/time/mtime/mtimecmp  counter and timer inputs
//   csr_mem_csr_rdata          old CSR value for rd writeback
//   csr_stall_flg              stage busy, upstream must hold
//   csr_trap_flg               redirect fetch this cycle
//   csr_trap_vector            redirect target, zero when no trap
module csr_stage #(
   parameter int FMAX_MHz = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_valid,
   input  logic [31:0] csr_reg_pc,
   input  logic [31:0] csr_inst,
   input  logic [63:0] csr_inst_id,
   input  logic [2:0]  csr_cmd,
   input  logic [31:0] csr_op1,
   input  logic [63:0] reg_cycle,
   input  logic [63:0] reg_time,
   input  logic [63:0] reg_mtime,
   input  logic [63:0] reg_mtimecmp,
   output logic [31:0] csr_mem_csr_rdata,
   output logic        csr_stall_flg,
   output logic        csr_trap_flg,
   output logic [31:0] csr_trap_vector
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EXEC = 1'b1;

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_RW    = 3'd1;
   localparam logic [2:0] CMD_RS    = 3'd2;
   localparam logic [2:0] CMD_RC    = 3'd3;
   localparam logic [2:0] CMD_ECALL = 3'd4;
   localparam logic [2:0] CMD_MRET  = 3'd5;

   logic [0:0]  state;
   logic [63:0] last_id;
   logic        last_id_vld;
   logic        irq_q;        // interrupt decision frozen at the IDLE cycle
   logic        st_mie;
   logic        st_mpie;
   logic        mie_mtie;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [29:0] mepc_w;       // mepc[1:0] always read as zero
   logic [31:0] mcause;
   logic [31:0] rdata;

   logic [11:0] csr_addr;
   logic        mtip;
   logic        irq_pending;
   logic        is_new;
   logic        start;
   logic        exec_ok;
   logic        take_irq;
   logic        do_ecall;
   logic        do_mret;
   logic        do_csr;
   logic        wr_en;
   logic [31:0] old_val;
   logic [31:0] wr_data;
   logic        unused_inst_bits;

   assign csr_addr         = csr_inst[31:20];
   assign unused_inst_bits = ^csr_inst[19:0];
   assign mtip             = (reg_mtime >= reg_mtimecmp);
   assign irq_pending      = st_mie & mie_mtie & mtip;
   assign is_new           = csr_valid && (!last_id_vld || (csr_inst_id != last_id));
   assign start            = (state == ST_IDLE) && is_new && ((csr_cmd != CMD_NONE) || irq_pending);

   // A dropped csr_valid during EXEC is an upstream flush and aborts everything.
   assign exec_ok  = (state == ST_EXEC) && csr_valid;
   assign take_irq = exec_ok && irq_q;
   assign do_ecall = exec_ok && !irq_q && (csr_cmd == CMD_ECALL);
   assign do_mret  = exec_ok && !irq_q && (csr_cmd == CMD_MRET);
   assign do_csr   = exec_ok && !irq_q &&
                     ((csr_cmd == CMD_RW) || (csr_cmd == CMD_RS) || (csr_cmd == CMD_RC));
   assign wr_en    = do_csr && ((csr_cmd == CMD_RW) || (csr_op1 != 32'd0));

   always_comb begin
      old_val = 32'd0;
      case (csr_addr)
         12'h300: old_val = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
         12'h304: old_val = {24'd0, mie_mtie, 7'd0};
         12'h305: old_val = mtvec;
         12'h340: old_val = mscratch;
         12'h341: old_val = {mepc_w, 2'b00};
         12'h342: old_val = mcause;
         12'h344: old_val = {24'd0, mtip, 7'd0};
         12'hC00: old_val = reg_cycle[31:0];
         12'hC80: old_val = reg_cycle[63:32];
         12'hC01: old_val = reg_time[31:0];
         12'hC81: old_val = reg_time[63:32];
         12'hF14: old_val = 32'd0;
         12'hFC0: old_val = 32'(FMAX_MHz);
         default: old_val = 32'd0;
      endcase
   end

   always_comb begin
      wr_data = csr_op1;
      case (csr_cmd)
         CMD_RS:  wr_data = old_val | csr_op1;
         CMD_RC:  wr_data = old_val & ~csr_op1;
         default: wr_data = csr_op1;
      endcase
   end

   // Reset gates stall so an instruction presented during reset never stalls.
   assign csr_stall_flg     = rst_n & start;
   assign csr_trap_flg      = take_irq | do_ecall | do_mret;
   assign csr_mem_csr_rdata = rdata;

   always_comb begin
      csr_trap_vector = 32'd0;
      if (take_irq || do_ecall) csr_trap_vector = {mtvec[31:2], 2'b00};
      else if (do_mret)         csr_trap_vector = {mepc_w, 2'b00};
   end

   // IDLE -> EXEC control state and instruction tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         irq_q       <= 1'b0;
         last_id     <= 64'd0;
         last_id_vld <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_EXEC;
                  irq_q <= irq_pending;
               end
            end
            default: begin
               state <= ST_IDLE;
               if (exec_ok) begin
                  last_id     <= csr_inst_id;
                  last_id_vld <= 1'b1;
               end
            end
         endcase
      end
   end

   // EXEC-cycle architectural state update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie   <= 1'b0;
         st_mpie  <= 1'b0;
         mie_mtie <= 1'b0;
         mtvec    <= 32'd0;
         mscratch <= 32'd0;
         mepc_w   <= 30'd0;
         mcause   <= 32'd0;
         rdata    <= 32'd0;
      end else begin
         if (take_irq || do_ecall) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            mepc_w  <= csr_reg_pc[31:2];
            mcause  <= take_irq ? 32'h8000_0007 : 32'd11;
         end else if (do_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end else if (wr_en) begin
            case (csr_addr)
               12'h300: begin
                  st_mie  <= wr_data[3];
                  st_mpie <= wr_data[7];
               end
               12'h304: mie_mtie <= wr_data[7];
               12'h305: mtvec    <= wr_data;
               12'h340: mscratch <= wr_data;
               12'h341: mepc_w   <= wr_data[31:2];
               12'h342: mcause   <= wr_data;
               default: ;
            endcase
         end
         if (exec_ok && !irq_q) rdata <= old_val;
      end
   end

endmodule

// File: tb/tb_csr_stage.sv
// Directed-vector bench for csr_stage: reset, CSR read/modify/write, traps,
// timer interrupt, repeated tags, flush and reset during EXEC.
module tb_csr_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_valid = 1'b0;
   logic [31:0] csr_reg_pc = 32'd0;
   logic [31:0] csr_inst = 32'd0;
   logic [63:0] csr_inst_id = 64'd0;
   logic [2:0]  csr_cmd = 3'd0;
   logic [31:0] csr_op1 = 32'd0;
   logic [63:0] reg_cycle = 64'd0;
   logic [63:0] reg_time = 64'd0;
   logic [63:0] reg_mtime = 64'd0;
   logic [63:0] reg_mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
   logic [31:0] csr_mem_csr_rdata;
   logic        csr_stall_flg;
   logic        csr_trap_flg;
   logic [31:0] csr_trap_vector;

   int tests = 0;
   int fails = 0;
   logic [63:0] next_id = 64'd1;

   csr_stage #(.FMAX_MHz(27)) dut (
      .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_reg_pc(csr_reg_pc),
      .csr_inst(csr_inst), .csr_inst_id(csr_inst_id), .csr_cmd(csr_cmd),
      .csr_op1(csr_op1), .reg_cycle(reg_cycle), .reg_time(reg_time),
      .reg_mtime(reg_mtime), .reg_mtimecmp(reg_mtimecmp),
      .csr_mem_csr_rdata(csr_mem_csr_rdata), .csr_stall_flg(csr_stall_flg),
      .csr_trap_flg(csr_trap_flg), .csr_trap_vector(csr_trap_vector)
   );

   always #5 clk = ~clk;

   // Present one new instruction for three cycles (IDLE, EXEC, following IDLE)
   // and return what was observed in each; then withdraw it.
   task automatic issue(input logic [2:0] cmd, input logic [11:0] addr,
                        input logic [31:0] op1, input logic [31:0] pc,
                        output logic s0, output logic t0, output logic s1,
                        output logic t1, output logic [31:0] v1,
                        output logic s2, output logic t2, output logic [31:0] rd);
      @(negedge clk);
      csr_valid   = 1'b1;
      csr_cmd     = cmd;
      csr_inst    = {addr, 20'h00073};
      csr_op1     = op1;
      csr_reg_pc  = pc;
      csr_inst_id = next_id;
      next_id     = next_id + 64'd1;
      #1 s0 = csr_stall_flg; t0 = csr_trap_flg;
      @(negedge clk);
      #1 s1 = csr_stall_flg; t1 = csr_trap_flg; v1 = csr_trap_vector;
      @(negedge clk);
      #1 s2 = csr_stall_flg; t2 = csr_trap_flg; rd = csr_mem_csr_rdata;
      csr_valid = 1'b0;
      csr_cmd   = 3'd0;
   endtask

   task automatic rdcsr(input logic [11:0] addr, output logic [31:0] rd);
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1;
      issue(3'd2, addr, 32'd0, 32'h1000, s0, t0, s1, t1, v1, s2, t2, rd);
   endtask

   task automatic test_reset;
      csr_valid   = 1'b1;
      csr_cmd     = 3'd1;
      csr_inst    = {12'h305, 20'h00073};
      csr_inst_id = 64'hABCD;
      #2;
      tests++; if (csr_stall_flg !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", csr_stall_flg); end
      tests++; if (csr_trap_flg !== 1'b0) begin fails++; $display("FAIL reset_trap got=%b exp=0", csr_trap_flg); end
      tests++; if (csr_trap_vector !== 32'd0) begin fails++; $display("FAIL reset_vector got=%h exp=0", csr_trap_vector); end
      tests++; if (csr_mem_csr_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", csr_mem_csr_rdata); end
      csr_valid = 1'b0;
      csr_cmd   = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rw_rs;
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1, rd;
      issue(3'd1, 12'h305, 32'h8000_0100, 32'h10, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b1 || s1 !== 1'b0 || s2 !== 1'b0) begin fails++; $display("FAIL rw_stall got=%b%b%b exp=100", s0, s1, s2); end
      tests++; if (t0 !== 1'b0 || t1 !== 1'b0 || v1 !== 32'd0) begin fails++; $display("FAIL rw_notrap got=%b%b v=%h exp=00 v=0", t0, t1, v1); end
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rw_old got=%h exp=0", rd); end
      issue(3'd2, 12'h305, 32'd0, 32'h14, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b1 || s1 !== 1'b0) begin fails++; $display("FAIL rs_stall got=%b%b exp=10", s0, s1); end
      tests++; if (rd !== 32'h8000_0100 || t1 !== 1'b0) begin fails++; $display("FAIL rs_read got=%h t=%b exp=80000100 t=0", rd, t1); end
      issue(3'd1, 12'h340, 32'h0000_F0F0, 32'h18, s0, t0, s1, t1, v1, s2, t2, rd);
      issue(3'd3, 12'h340, 32'h0000_00F0, 32'h1C, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (rd !== 32'h0000_F0F0) begin fails++; $display("FAIL rc_old got=%h exp=0000f0f0", rd); end
      rdcsr(12'h340, rd);
      tests++; if (rd !== 32'h0000_F000) begin fails++; $display("FAIL rc_result got=%h exp=0000f000", rd); end
   endtask

   task automatic test_ecall;
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1, rd;
      issue(3'd1, 12'h305, 32'h0000_0100, 32'h20, s0, t0, s1, t1, v1, s2, t2, rd);
      issue(3'd1, 12'h300, 32'h0000_0008, 32'h24, s0, t0, s1, t1, v1, s2, t2, rd);
      issue(3'd4, 12'h000, 32'd0, 32'h40, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b1 || t0 !== 1'b0) begin fails++; $display("FAIL ecall_first got=s%b t%b exp=s1 t0", s0, t0); end
      tests++; if (t1 !== 1'b1 || v1 !== 32'h100 || s1 !== 1'b0) begin fails++; $display("FAIL ecall_trap got=t%b v=%h s%b exp=t1 v=100 s0", t1, v1, s1); end
      tests++; if (t2 !== 1'b0) begin fails++; $display("FAIL ecall_pulse got=%b exp=0", t2); end
      rdcsr(12'h341, rd);
      tests++; if (rd !== 32'h40) begin fails++; $display("FAIL ecall_mepc got=%h exp=40", rd); end
      rdcsr(12'h342, rd);
      tests++; if (rd !== 32'd11) begin fails++; $display("FAIL ecall_mcause got=%h exp=b", rd); end
      rdcsr(12'h300, rd);
      tests++; if (rd !== 32'h80) begin fails++; $display("FAIL ecall_mstatus got=%h exp=80", rd); end
   endtask

   task automatic test_mret;
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1, rd;
      issue(3'd1, 12'h341, 32'h0000_0046, 32'h28, s0, t0, s1, t1, v1, s2, t2, rd);
      issue(3'd5, 12'h302, 32'd0, 32'h2C, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (t1 !== 1'b1 || v1 !== 32'h44) begin fails++; $display("FAIL mret_trap got=t%b v=%h exp=t1 v=44", t1, v1); end
      rdcsr(12'h300, rd);
      tests++; if (rd !== 32'h88) begin fails++; $display("FAIL mret_mstatus got=%h exp=88", rd); end
   endtask

   task automatic test_irq;
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1, rd;
      reg_mtime    = 64'd10;
      reg_mtimecmp = 64'd5;
      issue(3'd1, 12'h304, 32'h80, 32'h30, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (t1 !== 1'b0) begin fails++; $display("FAIL irq_mie_write got=%b exp=0", t1); end
      issue(3'd1, 12'h340, 32'h0000_DEAD, 32'h80, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b1 || t1 !== 1'b1 || v1 !== 32'h100) begin fails++; $display("FAIL irq_take got=s%b t%b v=%h exp=s1 t1 v=100", s0, t1, v1); end
      rdcsr(12'h342, rd);
      tests++; if (rd !== 32'h8000_0007) begin fails++; $display("FAIL irq_mcause got=%h exp=80000007", rd); end
      rdcsr(12'h341, rd);
      tests++; if (rd !== 32'h80) begin fails++; $display("FAIL irq_mepc got=%h exp=80", rd); end
      rdcsr(12'h340, rd);
      tests++; if (rd !== 32'h0000_F000) begin fails++; $display("FAIL irq_suppressed got=%h exp=0000f000", rd); end
      rdcsr(12'h300, rd);
      tests++; if (rd !== 32'h80) begin fails++; $display("FAIL irq_mstatus got=%h exp=80", rd); end
      rdcsr(12'h344, rd);
      tests++; if (rd !== 32'h80) begin fails++; $display("FAIL irq_mip got=%h exp=80", rd); end
      reg_mtime = 64'd4;
      issue(3'd1, 12'h300, 32'h8, 32'h84, s0, t0, s1, t1, v1, s2, t2, rd);
      issue(3'd2, 12'h344, 32'd0, 32'h90, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (t1 !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL irq_not_due got=t%b mip=%h exp=t0 mip=0", t1, rd); end
      issue(3'd0, 12'h000, 32'd0, 32'h94, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b0 || t1 !== 1'b0) begin fails++; $display("FAIL none_noop got=s%b t%b exp=s0 t0", s0, t1); end
      reg_mtime = 64'd10;
      issue(3'd0, 12'h000, 32'd0, 32'h98, s0, t0, s1, t1, v1, s2, t2, rd);
      tests++; if (s0 !== 1'b1 || t1 !== 1'b1 || v1 !== 32'h100) begin fails++; $display("FAIL irq_on_none got=s%b t%b v=%h exp=s1 t1 v=100", s0, t1, v1); end
      reg_mtime = 64'd0;
   endtask

   task automatic test_same_id;
      int nstall = 0;
      int ntrap = 0;
      logic [31:0] rd;
      @(negedge clk);
      csr_valid   = 1'b1;
      csr_cmd     = 3'd1;
      csr_inst    = {12'h340, 20'h00073};
      csr_op1     = 32'h1234;
      csr_inst_id = next_id;
      next_id     = next_id + 64'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (csr_stall_flg === 1'b1) nstall++;
         if (csr_trap_flg === 1'b1) ntrap++;
         if (i >= 2) begin
            tests++; if (csr_mem_csr_rdata !== 32'h0000_F000) begin fails++; $display("FAIL same_id_rdata cyc=%0d got=%h exp=0000f000", i, csr_mem_csr_rdata); end
         end
         if (i == 2) csr_op1 = 32'h9999;
         @(negedge clk);
      end
      csr_valid = 1'b0;
      csr_cmd   = 3'd0;
      tests++; if (nstall != 1 || ntrap != 0) begin fails++; $display("FAIL same_id_counts got=stall%0d trap%0d exp=stall1 trap0", nstall, ntrap); end
      rdcsr(12'h340, rd);
      tests++; if (rd !== 32'h1234) begin fails++; $display("FAIL same_id_write got=%h exp=1234", rd); end
   endtask

   task automatic test_counters;
      logic s0, t0, s1, t1, s2, t2;
      logic [31:0] v1, rd;
      reg_cycle = 64'h0000_0002_0000_0001;
      reg_time  = 64'h0000_0007_0000_0009;
      rdcsr(12'hC80, rd);
      tests++; if (rd !== 32'd2) begin fails++; $display("FAIL cycleh got=%h exp=2", rd); end
      rdcsr(12'hC00, rd);
      tests++; if (rd !== 32'd1) begin fails++; $display("FAIL cycle got=%h exp=1", rd); end
      rdcsr(12'hC81, rd);
      tests++; if (rd !== 32'd7) begin fails++; $display("FAIL timeh got=%h exp=7", rd); end
      issue(3'd1, 12'hFC0, 32'd5, 32'h50, s0, t0, s1, t1, v1, s2, t2, rd);
      rdcsr(12'hFC0, rd);
      tests++; if (rd !== 32'd27) begin fails++; $display("FAIL fmax got=%0d exp=27", rd); end
      rdcsr(12'hF14, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL mhartid got=%h exp=0", rd); end
      issue(3'd1, 12'h7C0, 32'h55, 32'h54, s0, t0, s1, t1, v1, s2, t2, rd);
      rdcsr(12'h7C0, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL unimpl got=%h exp=0", rd); end
   endtask

   task automatic test_flush;
      logic [31:0] rd;
      @(negedge clk);
      csr_valid   = 1'b1;
      csr_cmd     = 3'd1;
      csr_inst    = {12'h340, 20'h00073};
      csr_op1     = 32'hAAAA;
      csr_inst_id = next_id;
      next_id     = next_id + 64'd1;
      #1;
      tests++; if (csr_stall_flg !== 1'b1) begin fails++; $display("FAIL flush_stall got=%b exp=1", csr_stall_flg); end
      @(negedge clk);
      csr_valid = 1'b0;
      #1;
      tests++; if (csr_trap_flg !== 1'b0 || csr_stall_flg !== 1'b0) begin fails++; $display("FAIL flush_exec got=t%b s%b exp=t0 s0", csr_trap_flg, csr_stall_flg); end
      csr_cmd = 3'd0;
      rdcsr(12'h340, rd);
      tests++; if (rd !== 32'h1234) begin fails++; $display("FAIL flush_nowrite got=%h exp=1234", rd); end
   endtask

   task automatic test_reset_mid_exec;
      logic [31:0] rd;
      @(negedge clk);
      csr_valid   = 1'b1;
      csr_cmd     = 3'd4;
      csr_inst    = {12'h000, 20'h00073};
      csr_reg_pc  = 32'h60;
      csr_inst_id = next_id;
      next_id     = next_id + 64'd1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++; if (csr_trap_flg !== 1'b0 || csr_stall_flg !== 1'b0 || csr_trap_vector !== 32'd0) begin
         fails++; $display("FAIL rst_exec got=t%b s%b v=%h exp=t0 s0 v=0", csr_trap_flg, csr_stall_flg, csr_trap_vector);
      end
      tests++; if (csr_mem_csr_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", csr_mem_csr_rdata); end
      @(negedge clk);
      csr_valid = 1'b0;
      csr_cmd   = 3'd0;
      rst_n     = 1'b1;
      rdcsr(12'h305, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mtvec got=%h exp=0", rd); end
      rdcsr(12'h340, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mscratch got=%h exp=0", rd); end
      rdcsr(12'h341, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mepc got=%h exp=0", rd); end
      rdcsr(12'h300, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mstatus got=%h exp=0", rd); end
      rdcsr(12'h304, rd);
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mie got=%h exp=0", rd); end
   endtask

   initial begin
      test_reset();
      test_rw_rs();
      test_ecall();
      test_mret();
      test_irq();
      test_same_id();
      test_counters();
      test_flush();
      test_reset_mid_exec();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
